// File: rtl/muldiv_unit_if.sv
// Execute-stage connection between the pipeline/hazard logic and the iterative mul/div unit.
// StartE is a one-cycle launch strobe, and the unit accepts it only while BusyE is 0; MulDivStall is the unit's hold-off to the hazard unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic             StartE;
  logic [1:0]       MulDivOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             MtHiE;
  logic             MtLoE;
  logic             MulDivD;
  logic             HiLoAccessD;
  logic [WIDTH-1:0] HiE;
  logic [WIDTH-1:0] LoE;
  logic             BusyE;
  logic             MulDivStall;
  logic [1:0]       StateDbg;

  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, MtHiE, MtLoE, MulDivD, HiLoAccessD,
    input  HiE, LoE, BusyE, MulDivStall, StateDbg
  );

  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, MtHiE, MtLoE, MulDivD, HiLoAccessD,
    output HiE, LoE, BusyE, MulDivStall, StateDbg
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit that owns HI/LO.
// An operation takes one latch cycle, WIDTH step cycles and one sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } stateT;

  stateT            state;
  logic [CW-1:0]    count;
  logic             busyReg;
  logic             isDiv;
  logic             negRes;
  logic             negRem;
  logic             divZero;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;

  logic             signedOp;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic             divFits;
  logic [WIDTH-1:0] divDiff;
  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0] quotFix;
  logic [WIDTH-1:0] remFix;

  always_comb begin
    signedOp = ~bus.MulDivOpE[0];
    signA    = signedOp & bus.SrcAE[WIDTH-1];
    signB    = signedOp & bus.SrcBE[WIDTH-1];
    absA     = signA ? -bus.SrcAE : bus.SrcAE;
    absB     = signB ? -bus.SrcBE : bus.SrcBE;

    // Multiply: accHi collects partial sums, accLo shifts the multiplier out as product bits arrive.
    mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);

    // Divide: accHi is the partial remainder, accLo shifts the dividend out and quotient bits in.
    divShift = {accHi, accLo[WIDTH-1]};
    divFits  = (divShift >= {1'b0, operand});
    divDiff  = divShift[WIDTH-1:0] - operand;

    prodMag  = {accHi, accLo};
    prodFix  = negRes ? -prodMag : prodMag;
    // With a zero divisor the remainder register ends up holding |dividend|; re-signing it restores the dividend.
    quotFix  = divZero ? '1 : (negRes ? -accLo : accLo);
    remFix   = negRem ? -accHi : accHi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      busyReg <= 1'b0;
      isDiv   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
      operand <= '0;
      accHi   <= '0;
      accLo   <= '0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.StartE) begin
            isDiv   <= bus.MulDivOpE[1];
            operand <= bus.MulDivOpE[1] ? absB : absA;
            accHi   <= '0;
            accLo   <= bus.MulDivOpE[1] ? absA : absB;
            negRes  <= signA ^ signB;
            negRem  <= signA;
            divZero <= (bus.SrcBE == '0);
            count   <= CW'(WIDTH);
            busyReg <= 1'b1;
            state   <= RUN;
          end else begin
            if (bus.MtHiE) hiReg <= bus.SrcAE;
            if (bus.MtLoE) loReg <= bus.SrcAE;
          end
        end
        RUN: begin
          if (isDiv) begin
            accHi <= divFits ? divDiff : divShift[WIDTH-1:0];
            accLo <= {accLo[WIDTH-2:0], divFits};
          end else begin
            accHi <= mulSum[WIDTH:1];
            accLo <= {mulSum[0], accLo[WIDTH-1:1]};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (isDiv) begin
            hiReg <= remFix;
            loReg <= quotFix;
          end else begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.HiE         = hiReg;
  assign bus.LoE         = loReg;
  assign bus.BusyE       = busyReg;
  assign bus.StateDbg    = state;
  // The StartE term covers the launch cycle, before BusyE has risen.
  assign bus.MulDivStall = (busyReg | bus.StartE) & (bus.MulDivD | bus.HiLoAccessD);

endmodule
